conv_acc_requant: RTL and testbench
===================================

# conv_acc_requant

Downstream consumer of the 9-input FP16-lane adder tree (18-bit signed sum, 2-cycle latency, no valid or stall). It accumulates one tree sum per input channel into a 32-bit partial sum and adds a per-group bias. At the end of each group it rounds, shifts, optionally applies ReLU, saturates to 16 bits, and queues the result in a 2-entry output FIFO with a valid/ready handshake toward the writeback stage.

## Interface
Parameters:
- IN_W, 18, tree sum width
- ACC_W, 32, accumulator width
- OUT_W, 16, output width
- CH_W, 8, channel-count width (groups of 1..256 sums)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tree_in_valid  in  1  high in the cycle the tree's 9 inputs are presented
- tree_sum  in  IN_W  tree dout, signed
- acc_clear  in  1  synchronous abort of the current group
- cfg_num_ch_m1  in  CH_W  sums per group minus 1
- cfg_bias  in  ACC_W  signed bias
- cfg_shift  in  5  arithmetic right shift, 0..31
- cfg_relu  in  1  clamp negatives to 0
- busy  out  1  state != IDLE
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts
- out_data  out  OUT_W  signed result, FIFO head
- err_overflow  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- A 2-bit valid delay line realigns tree_in_valid to tree_sum. sum_valid = tree_in_valid delayed 2 cycles.
- FSM states IDLE and ACCUM:
  - IDLE + sum_valid: latch cfg_* into shadow registers, acc <= sext(tree_sum) + cfg_bias, cnt <= 1.
  - If cfg_num_ch_m1 == 0, skip ACCUM and go straight to finalize.
  - ACCUM + sum_valid: acc <= acc + sext(tree_sum), cnt++.
  - The sum taken when cnt == shadow num_ch_m1 finalizes the group and returns to IDLE.
- Finalize stage 1 (registered): fin = acc + sext(tree_sum), ACC_W wrap arithmetic.
- Finalize stage 2 (registered):
  - r = (fin + (1 << (shift-1))) >>> shift; r = fin when shift == 0.
  - If relu and r < 0, r = 0.
  - Saturate r to [-32768, 32767].
  - Push r into the FIFO.
- FIFO: 2 entries, in-order.
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle are both accepted, including when full.
  - Push while full with no pop drops the result and sets err_overflow.
- acc_clear:
  - FSM -> IDLE, cnt <= 0, valid delay line zeroed; acc_clear wins over a same-cycle sum_valid.
  - Finalize stages already in flight still complete into the FIFO.
  - Clears err_overflow.
  - Does not flush the FIFO.
- Config inputs may change at any time. Only values latched at group start are used for that group.

## Timing
- Reset value 0 for: state (IDLE), cnt, acc, shadow cfg, delay line, finalize registers, FIFO pointers, out_valid, out_data, err_overflow, busy.
- Last-channel tree_in_valid at cycle t: sum_valid at t+2, fin at t+3, FIFO entry and out_valid at t+4 if the FIFO was empty.
- Throughput: one sum per cycle with back-to-back groups. The first sum of group n+1 may arrive in the cycle after the last sum of group n.
- out_data/out_valid come from registers with no combinational path from out_ready; out_data holds while out_valid & !out_ready.
- rst_n asserted mid-group discards all state, including FIFO contents.

## Structure
- conv_acc_pkg holds:
  - state enum (IDLE, ACCUM)
  - width constants IN_W, ACC_W, OUT_W, CH_W
  - saturation limits OUT_MAX = 32767, OUT_MIN = -32768
- Sub-module: sync_fifo2 (2-entry, valid/ready, full/empty, registered output), reusable elsewhere.

## Test plan
- num_ch_m1=0, bias=0, shift=0, relu=0, tree_in_valid with sum 100 at t -> out_valid and out_data=100 at t+4.
- num_ch_m1=2, bias=10, sums 5, -3, 7 back-to-back, shift=1 -> fin=19, out_data=10; fin=-3 with shift=1 -> out_data=-1.
- Saturation: bias=40000, sum 0 -> 32767; bias=-40000 -> -32768; relu=1 with fin=-5 -> 0.
- out_ready=0, three single-channel groups (1, 2, 3) -> FIFO holds 1, 2; 3 dropped; err_overflow=1. Then out_ready=1 -> 1 then 2, out_valid falls.
- num_ch_m1=3, two sums then acc_clear -> no output, busy=0. Next group (num_ch_m1=0, sum 42) -> 42.
- cfg_bias changed mid-group and rst_n pulsed during ACCUM -> the group uses the latched bias; after reset all outputs are 0 and the next group is correct.

Source files
------------

// File: rtl/conv_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_acc_pkg
// Description : Shared types and constants for the convolution accumulator /
//               requantiser slice: FSM state encoding, datapath widths and
//               output saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_acc_pkg;

    localparam int IN_W    = 18;      // adder-tree sum width
    localparam int ACC_W   = 32;      // partial-sum accumulator width
    localparam int OUT_W   = 16;      // requantised output width
    localparam int CH_W    = 8;       // channel-count width

    localparam int OUT_MAX = 32767;
    localparam int OUT_MIN = -32768;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage : conv_acc_pkg
`default_nettype wire

// File: rtl/conv_acc_requant_sync_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo2
// Description : Two-entry in-order FIFO with a valid/ready read side. The head
//               entry is taken straight from the storage registers, so the
//               read data has no combinational path from ready_i and holds
//               while the consumer stalls. A push is accepted when full only
//               if a pop happens in the same cycle.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               push_i       - write request, data_i - write data
//               ready_i      - consumer accepts head (pop when !empty_o)
//               data_o       - head entry
//               full_o       - both entries occupied
//               empty_o      - no entry occupied (valid = !empty_o)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic             w_pop;
    logic             w_push;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign data_o  = mem_q[rd_q];

    assign w_pop  = ~empty_o & ready_i;
    // When full, the slot being written is the one being popped this cycle.
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (w_pop) begin
                rd_q <= ~rd_q;
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule : sync_fifo2
`default_nettype wire

// File: rtl/conv_acc_requant.sv
`default_nettype none
// ============================================================================
// Module      : conv_acc_requant
// Description : Accumulates one adder-tree sum per input channel plus a
//               per-group bias, then rounds, shifts, optionally applies ReLU,
//               saturates to OUT_W bits and queues the result in a 2-entry
//               output FIFO.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               tree_in_valid       - tree inputs presented (sum 2 cycles later)
//               tree_sum            - signed tree output
//               acc_clear           - abort current group, clear err_overflow
//               cfg_num_ch_m1       - sums per group minus one
//               cfg_bias/shift/relu - group configuration, latched at start
//               busy                - a group is being accumulated
//               out_valid/out_ready - result handshake, out_data - FIFO head
//               err_overflow        - sticky: a result was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_requant #(
    parameter int IN_W  = 18,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int CH_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tree_in_valid,
    input  logic [IN_W-1:0]  tree_sum,
    input  logic             acc_clear,
    input  logic [CH_W-1:0]  cfg_num_ch_m1,
    input  logic [ACC_W-1:0] cfg_bias,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             err_overflow
);

    import conv_acc_pkg::*;

    localparam logic signed [ACC_W:0] c_sat_max = OUT_MAX;
    localparam logic signed [ACC_W:0] c_sat_min = OUT_MIN;

    state_e           state_q, state_d;
    logic [1:0]       vld_q;
    logic [CH_W-1:0]  cnt_q;
    logic [CH_W-1:0]  nch_q;
    logic [4:0]       shift_q;
    logic             relu_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] fin_q;
    logic             fin_v_q;
    logic [4:0]       fin_shift_q;
    logic             fin_relu_q;
    logic             err_q;

    logic                    w_sum_valid;
    logic [ACC_W-1:0]        w_sext;
    logic                    w_start;
    logic                    w_last;
    logic                    w_step;
    logic                    w_fin;
    logic signed [ACC_W:0]   w_wide;
    logic signed [ACC_W:0]   w_rnd;
    logic [OUT_W-1:0]        w_res;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_drop;

    // The delay line realigns tree_in_valid with the tree's 2-cycle output.
    assign w_sum_valid = vld_q[1];
    assign w_sext      = {{(ACC_W-IN_W){tree_sum[IN_W-1]}}, tree_sum};

    assign w_start = w_sum_valid & ~acc_clear & (state_q == IDLE);
    assign w_last  = w_sum_valid & ~acc_clear & (state_q == ACCUM) & (cnt_q == nch_q);
    assign w_step  = w_sum_valid & ~acc_clear & (state_q == ACCUM) & (cnt_q != nch_q);
    // A single-channel group finalizes directly from IDLE.
    assign w_fin   = (w_start & (cfg_num_ch_m1 == '0)) | w_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (acc_clear) begin
            state_d = IDLE;
        end else if (w_sum_valid) begin
            case (state_q)
                IDLE:    if (cfg_num_ch_m1 != '0) state_d = ACCUM;
                ACCUM:   if (cnt_q == nch_q)      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != IDLE);
    end

    // ---------------- Accumulator and finalize stage 1 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= 2'b00;
            cnt_q       <= '0;
            nch_q       <= '0;
            shift_q     <= 5'd0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            fin_q       <= '0;
            fin_v_q     <= 1'b0;
            fin_shift_q <= 5'd0;
            fin_relu_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vld_q <= acc_clear ? 2'b00 : {vld_q[0], tree_in_valid};

            if (acc_clear) begin
                cnt_q <= '0;
            end else if (w_start) begin
                nch_q   <= cfg_num_ch_m1;
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
                acc_q   <= w_sext + cfg_bias;
                cnt_q   <= CH_W'(1);
            end else if (w_step) begin
                acc_q <= acc_q + w_sext;
                cnt_q <= cnt_q + CH_W'(1);
            end else if (w_last) begin
                cnt_q <= '0;
            end

            // Shift/relu travel with the result so the next group may
            // overwrite the shadow registers while this one finishes.
            fin_v_q <= w_fin;
            if (w_fin) begin
                fin_q       <= w_start ? (w_sext + cfg_bias) : (acc_q + w_sext);
                fin_shift_q <= w_start ? cfg_shift : shift_q;
                fin_relu_q  <= w_start ? cfg_relu  : relu_q;
            end

            err_q <= w_drop | (err_q & ~acc_clear);
        end
    end

    // ---------------- Finalize stage 2: round, shift, relu, saturate ----------
    // One guard bit keeps the rounding add from wrapping near the top of range.
    always_comb begin
        w_wide = $signed({fin_q[ACC_W-1], fin_q});
        if (fin_shift_q == 5'd0) begin
            w_rnd = w_wide;
        end else begin
            w_rnd = (w_wide + $signed((ACC_W+1)'(1) << (fin_shift_q - 5'd1))) >>> fin_shift_q;
        end
        if (fin_relu_q && w_rnd[ACC_W]) begin
            w_rnd = '0;
        end
        if (w_rnd > c_sat_max) begin
            w_res = c_sat_max[OUT_W-1:0];
        end else if (w_rnd < c_sat_min) begin
            w_res = c_sat_min[OUT_W-1:0];
        end else begin
            w_res = w_rnd[OUT_W-1:0];
        end
    end

    // The FIFO storage doubles as the stage-2 result register.
    sync_fifo2 #(
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fin_v_q),
        .data_i  (w_res),
        .ready_i (out_ready),
        .data_o  (out_data),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign out_valid    = ~w_empty;
    assign w_drop       = fin_v_q & w_full & ~(out_valid & out_ready);
    assign err_overflow = err_q;

endmodule : conv_acc_requant
`default_nettype wire

// File: tb/tb_conv_acc_requant.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_acc_requant
// Description : Self-checking bench for conv_acc_requant. A small model of the
//               adder tree delays each sum by two cycles behind tree_in_valid.
//               Directed vectors with hand-computed results are applied from a
//               table, followed by hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_acc_requant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tree_in_valid;
    logic [17:0] tree_sum = '0;
    logic [17:0] tv_sum = '0;
    logic [17:0] d1 = '0;
    logic        acc_clear;
    logic [7:0]  cfg_num_ch_m1;
    logic [31:0] cfg_bias;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int nch_m1;
        int bias;
        int shift;
        int relu;
        int n;
        int s [4];
        int exp;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    // Adder-tree stand-in: dout follows the presented inputs by two cycles.
    always @(posedge clk) begin
        d1       <= tv_sum;
        tree_sum <= d1;
    end

    conv_acc_requant #(
        .IN_W  (18),
        .ACC_W (32),
        .OUT_W (16),
        .CH_W  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tree_in_valid (tree_in_valid),
        .tree_sum      (tree_sum),
        .acc_clear     (acc_clear),
        .cfg_num_ch_m1 (cfg_num_ch_m1),
        .cfg_bias      (cfg_bias),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .err_overflow  (err_overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input int s);
        tree_in_valid = 1'b1;
        tv_sum        = 18'(s);
        @(negedge clk);
        tree_in_valid = 1'b0;
    endtask

    task automatic set_cfg(input int nch, input int bias, input int shift, input int relu);
        cfg_num_ch_m1 = 8'(nch);
        cfg_bias      = 32'(bias);
        cfg_shift     = 5'(shift);
        cfg_relu      = 1'(relu);
    endtask

    task automatic wait_out(input string name);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check({name, "_valid"}, int'(out_valid), 1);
    endtask

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    initial begin
        vecs[0]  = '{0,          0,  0, 0, 1, '{100, 0, 0, 0},          100};
        vecs[1]  = '{2,         10,  1, 0, 3, '{5, -3, 7, 0},            10};
        vecs[2]  = '{0,          0,  1, 0, 1, '{-3, 0, 0, 0},            -1};
        vecs[3]  = '{0,      40000,  0, 0, 1, '{0, 0, 0, 0},          32767};
        vecs[4]  = '{0,     -40000,  0, 0, 1, '{0, 0, 0, 0},         -32768};
        vecs[5]  = '{0,          0,  0, 1, 1, '{-5, 0, 0, 0},             0};
        vecs[6]  = '{3,       -100,  2, 0, 4, '{1000, -200, 50, 3},     188};
        vecs[7]  = '{1,          0,  4, 0, 2, '{-131072, -131072, 0, 0}, -16384};
        vecs[8]  = '{0, 2147483647,  0, 0, 1, '{1, 0, 0, 0},         -32768};
        vecs[9]  = '{0, 2147483647, 31, 0, 1, '{0, 0, 0, 0},              1};
        vecs[10] = '{0,          7,  0, 1, 1, '{8, 0, 0, 0},             15};
        vecs[11] = '{0,          0,  3, 0, 1, '{-5, 0, 0, 0},            -1};

        rst_n         = 1'b0;
        tree_in_valid = 1'b0;
        acc_clear     = 1'b0;
        out_ready     = 1'b1;
        set_cfg(0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy",   int'(busy), 0);
        check("rst_valid",  int'(out_valid), 0);
        check("rst_data",   sdata(), 0);
        check("rst_err",    int'(err_overflow), 0);

        // Latency: single-channel sum at t, result visible at t+4.
        send(100);
        tick();
        tick();
        check("lat_t3_valid", int'(out_valid), 0);
        tick();
        check("lat_t4_valid", int'(out_valid), 1);
        check("lat_t4_data",  sdata(), 100);
        tick();
        check("lat_popped",   int'(out_valid), 0);

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            set_cfg(vecs[i].nch_m1, vecs[i].bias, vecs[i].shift, vecs[i].relu);
            for (int k = 0; k < vecs[i].n; k++) send(vecs[i].s[k]);
            wait_out($sformatf("vec%0d", i));
            check($sformatf("vec%0d_data", i), sdata(), vecs[i].exp);
            tick();
        end

        // Back-to-back groups; config for the second changes after the first latched.
        set_cfg(1, 0, 0, 0);
        send(1);
        send(2);
        send(50);
        set_cfg(0, 100, 0, 0);
        wait_out("b2b_a");
        check("b2b_a_data", sdata(), 3);
        tick();
        check("b2b_b_valid", int'(out_valid), 1);
        check("b2b_b_data",  sdata(), 150);
        tick();
        check("b2b_empty", int'(out_valid), 0);

        // FIFO overflow with the consumer stalled.
        out_ready = 1'b0;
        set_cfg(0, 0, 0, 0);
        send(1);
        send(2);
        send(3);
        repeat (6) tick();
        check("ovf_valid", int'(out_valid), 1);
        check("ovf_head",  sdata(), 1);
        check("ovf_err",   int'(err_overflow), 1);
        out_ready = 1'b1;
        tick();
        check("ovf_second_valid", int'(out_valid), 1);
        check("ovf_second_data",  sdata(), 2);
        tick();
        check("ovf_drained", int'(out_valid), 0);
        check("ovf_err_sticky", int'(err_overflow), 1);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        check("ovf_err_cleared", int'(err_overflow), 0);

        // Abort a group midway with acc_clear.
        set_cfg(3, 0, 0, 0);
        send(10);
        send(20);
        repeat (3) tick();
        check("clr_busy_before", int'(busy), 1);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        check("clr_busy_after", int'(busy), 0);
        repeat (6) tick();
        check("clr_no_output", int'(out_valid), 0);
        set_cfg(0, 0, 0, 0);
        send(42);
        wait_out("clr_next");
        check("clr_next_data", sdata(), 42);
        tick();

        // Bias changed after group start: latched value is used.
        set_cfg(2, 1000, 0, 0);
        send(1);
        send(2);
        send(3);
        cfg_bias = 32'd5;
        wait_out("latch");
        check("latch_data", sdata(), 1006);
        tick();

        // Reset mid-group with a result parked in the FIFO.
        out_ready = 1'b0;
        set_cfg(0, 0, 0, 0);
        send(99);
        repeat (5) tick();
        check("prerst_valid", int'(out_valid), 1);
        check("prerst_data",  sdata(), 99);
        set_cfg(3, 0, 0, 0);
        send(4);
        send(5);
        repeat (3) tick();
        check("prerst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("inrst_busy",  int'(busy), 0);
        check("inrst_valid", int'(out_valid), 0);
        check("inrst_data",  sdata(), 0);
        check("inrst_err",   int'(err_overflow), 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        set_cfg(0, 0, 0, 0);
        send(7);
        wait_out("postrst");
        check("postrst_data", sdata(), 7);
        tick();
        check("postrst_empty", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_conv_acc_requant
`default_nettype wire
